nubus_target: RTL
=================

Name: nubus_target

Overview:
- Synthesizable NuBus slave responder: watches /START, decodes slot/expansion address and transfer mode, runs one handshake on the local memory port (mem_*), then returns /ACK with status and read data.
- Answers the master cycles (word, half, byte; read and write) and feeds the same mem_* port used by nubus_memory.
- Split tri-state pins (_i/_o/_oe); top-level pads merge them.

Parameters:
TIMEOUT_CLOCKS, 255, mem_ready watchdog limit in clocks (used only with the optional feature).

Ports:
mem_clk  in  1  clock, = ~nub_clkn; rising edge = NuBus sampling edge
mem_reset  in  1  asynchronous, active-high reset
nub_idn  in  4  inverted slot ID
nub_startn  in  1  /START
nub_adn_i  in  32  /AD sampled
nub_tm0n_i, nub_tm1n_i  in  1 each  /TM sampled
nub_adn_o  out  32  /AD read data
nub_adn_oe  out  1  /AD drive enable
nub_tm0n_o, nub_tm1n_o  out  1 each  /TM status
nub_tmn_oe  out  1  /TM drive enable
nub_ackn_o  out  1  /ACK (drive 0 when asserted)
nub_ackn_oe  out  1  /ACK drive enable
mem_valid  out  1  memory request
mem_ready  in  1  memory done
mem_write  out  4  byte write strobes, 0 = read
mem_addr  out  32  byte address, [1:0]=00
mem_wdata  out  32  write data, lane-positioned
mem_rdata  in  32  read data
mem_myslot  out  1  hit in slot space Fsxxxxxx
mem_myexp  out  1  hit in super-slot space sxxxxxxx

Behaviour:
- Reset (async, any state): state IDLE, every output 0 except nub_ackn_o=1, nub_tm0n_o=nub_tm1n_o=1, nub_adn_o=all ones. An in-flight cycle is abandoned: no ACK, mem_valid drops at once.
- Decode: slot=~nub_idn, A=~nub_adn_i. myslot = A[31:24]=={4'hF,slot}; myexp = A[31:28]==slot and slot!=0. Hit = myslot|myexp.
- Mode: TM1=~/TM1, TM0=~/TM0. TM1=1 = write. TM0=0 = byte, lane A[1:0]. TM0=1 with A[1:0]: 00 = half 0 (lanes 0-1), 10 = half 1 (lanes 2-3), 11 = word, 01 = block (unsupported: ACK with ERROR, no memory access).
- FSM:
  - IDLE: on /START=0 with hit, latch address, mode, lanes and myslot/myexp (held until return to IDLE). Write -> WDATA; read -> MEM. /START with miss is ignored.
  - WDATA: latch ~nub_adn_i into mem_wdata -> MEM.
  - MEM: mem_valid=1; mem_write=lanes for writes, 0 for reads. A cycle with mem_valid&mem_ready ends the access and latches mem_rdata with unselected lanes forced to 0 -> ACK. mem_valid deasserts the cycle after ready.
  - ACK (exactly 1 clock): nub_ackn_oe=1, nub_ackn_o=0, nub_tmn_oe=1, /TM = ~status. Reads also drive nub_adn_oe=1, nub_adn_o = ~rdata. -> IDLE.
- Status (active-high TM1,TM0): 00 complete, 01 error, 10 timeout, 11 try-again-later (never generated).
- Latency from the START clock (zero-wait memory, ready in first MEM cycle): read ACK at +2, write ACK at +3. Each extra wait clock adds one.
- /START seen in a non-IDLE state is ignored. Back-to-back: a new START may be taken in the IDLE clock that follows ACK.

Optional Feature:
NUBUS_TARGET_TIMEOUT_EN:
- Defined: an 8-bit+ counter runs in MEM. If ready has not arrived after TIMEOUT_CLOCKS clocks, drop mem_valid and ACK with status 10 (timeout); read data is all zeros. A late mem_ready is ignored.
- Undefined: MEM waits forever; no counter is synthesized.

Decomposition:
- Package nubus_pkg: status constants (COMPLETE/ERROR/TIMEOUT/TRY_AGAIN_LATER), TM/AD mode constants, FSM state enum, lane-mask function.
- Sub-module nubus_lane_decode (combinational): {TM0,A1,A0} -> 4-bit lane mask plus block flag.

Test Plan:
- Slot 0, word write 0x87654321 to F0000000 (/TM=00, /AD[1:0]=00): mem_write=1111, mem_wdata=0x87654321, ACK at +3, status complete. Word read returns 0x87654321.
- Half 1 write 0x87654321 to F0000008 on zeroed memory: mem_write=1100; read back returns 0x87650000.
- Byte 2 write to F0000014: mem_write=0100; read returns 0x00650000. Repeat with byte 0, 1, 3 and half 0.
- Address E0000000 with slot 0: no mem_valid, no ACK. Slot 3 at 30001000: mem_myexp=1, mem_myslot=0.
- Block mode (TM0=1, A=01): ACK status error, mem_valid never asserted. Reset pulsed during MEM: mem_valid and ACK go inactive immediately, next START is served normally.
- With NUBUS_TARGET_TIMEOUT_EN and mem_ready held 0: ACK at MEM entry + 255 clocks, status timeout.

Source files
------------

// File: rtl/nubus_pkg.sv
// nubus_pkg: shared constants and helpers for the NuBus slave responder.
// Holds transfer status codes, /TM and /AD mode encodings, FSM state codes
// and the byte-lane helpers used by nubus_lane_decode and nubus_target.
package nubus_pkg;

  // Transfer status returned on TM1,TM0 (active-high view).
  localparam logic [1:0] STATUS_COMPLETE        = 2'b00;
  localparam logic [1:0] STATUS_ERROR           = 2'b01;
  localparam logic [1:0] STATUS_TIMEOUT         = 2'b10;
  localparam logic [1:0] STATUS_TRY_AGAIN_LATER = 2'b11;

  // TM1 selects direction, TM0 selects byte vs. wider transfers.
  localparam logic TM1_READ  = 1'b0;
  localparam logic TM1_WRITE = 1'b1;
  localparam logic TM0_BYTE  = 1'b0;
  localparam logic TM0_WIDE  = 1'b1;

  // A[1:0] meaning when TM0 selects a wide transfer.
  localparam logic [1:0] AD_HALF0 = 2'b00;
  localparam logic [1:0] AD_BLOCK = 2'b01;
  localparam logic [1:0] AD_HALF1 = 2'b10;
  localparam logic [1:0] AD_WORD  = 2'b11;

  // Responder FSM state codes.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WDATA = 2'd1;
  localparam logic [1:0] S_MEM   = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  // Byte-lane mask for a transfer; block mode yields no lanes.
  function automatic logic [3:0] lane_mask(input logic tm0, input logic [1:0] a);
    logic [3:0] m;
    m = 4'b0000;
    if (tm0 == TM0_BYTE) begin
      m = 4'b0001 << a;
    end else begin
      case (a)
        AD_HALF0: m = 4'b0011;
        AD_HALF1: m = 4'b1100;
        AD_WORD:  m = 4'b1111;
        default:  m = 4'b0000;
      endcase
    end
    return m;
  endfunction

  // Expand a 4-bit lane mask into a 32-bit byte mask.
  function automatic logic [31:0] lane_bits(input logic [3:0] lanes);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{lanes[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/nubus_lane_decode.sv
// nubus_lane_decode: combinational transfer-mode decode.
// Maps {TM0, A1, A0} to the active byte lanes and flags block transfers,
// which this responder refuses.
module nubus_lane_decode
  import nubus_pkg::*;
(
  input  logic       tm0,
  input  logic [1:0] a,
  output logic [3:0] lanes,
  output logic       block
);

  // Lane mask and block detection from the sampled mode bits.
  always_comb begin
    lanes = lane_mask(tm0, a);
    block = (tm0 == TM0_WIDE) && (a == AD_BLOCK);
  end

endmodule

// File: rtl/nubus_target.sv
// nubus_target: NuBus slave responder feeding a simple valid/ready memory port.
// Decodes slot (Fsxxxxxx) and super-slot (sxxxxxxx) hits on /START, runs one
// memory handshake, then returns a single-clock /ACK with status and read data.
// Optional feature macro: NUBUS_TARGET_TIMEOUT_EN adds a mem_ready watchdog
// that ends a stuck access with a timeout status after TIMEOUT_CLOCKS clocks.
module nubus_target
  import nubus_pkg::*;
#(
  parameter int TIMEOUT_CLOCKS = 255
) (
  input  logic        mem_clk,
  input  logic        mem_reset,
  input  logic [3:0]  nub_idn,
  input  logic        nub_startn,
  input  logic [31:0] nub_adn_i,
  input  logic        nub_tm0n_i,
  input  logic        nub_tm1n_i,
  output logic [31:0] nub_adn_o,
  output logic        nub_adn_oe,
  output logic        nub_tm0n_o,
  output logic        nub_tm1n_o,
  output logic        nub_tmn_oe,
  output logic        nub_ackn_o,
  output logic        nub_ackn_oe,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [3:0]  mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_myslot,
  output logic        mem_myexp
);

  logic [3:0]  slot;
  logic [31:0] a;
  logic        tm1;
  logic        tm0;
  logic        hit_slot;
  logic        hit_exp;
  logic        hit;
  logic [3:0]  dec_lanes;
  logic        dec_block;
  logic        timeout_hit;

  logic [1:0]  state;
  logic [29:0] addr_q;
  logic [3:0]  lanes_q;
  logic        write_q;
  logic [1:0]  status_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        myslot_q;
  logic        myexp_q;
  logic        ack;

  assign slot     = ~nub_idn;
  assign a        = ~nub_adn_i;
  assign tm1      = ~nub_tm1n_i;
  assign tm0      = ~nub_tm0n_i;
  assign hit_slot = (a[31:24] == {4'hF, slot});
  assign hit_exp  = (a[31:28] == slot) && (slot != 4'h0);
  assign hit      = hit_slot | hit_exp;

  nubus_lane_decode u_lane_decode (
    .tm0   (tm0),
    .a     (a[1:0]),
    .lanes (dec_lanes),
    .block (dec_block)
  );

`ifdef NUBUS_TARGET_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CLOCKS + 1) < 8) ? 8 : $clog2(TIMEOUT_CLOCKS + 1);
  logic [CNT_W-1:0] wait_cnt;

  // Count MEM clocks without mem_ready; cleared whenever outside MEM.
  always_ff @(posedge mem_clk or posedge mem_reset) begin
    if (mem_reset) begin
      wait_cnt <= '0;
    end else if (state == S_MEM && !mem_ready) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CLOCKS - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Responder FSM: accept a hit, gather write data, run the memory access, ACK.
  always_ff @(posedge mem_clk or posedge mem_reset) begin
    if (mem_reset) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      lanes_q  <= '0;
      write_q  <= 1'b0;
      status_q <= STATUS_COMPLETE;
      wdata_q  <= '0;
      rdata_q  <= '0;
      myslot_q <= 1'b0;
      myexp_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!nub_startn && hit) begin
            addr_q   <= a[31:2];
            lanes_q  <= dec_lanes;
            write_q  <= tm1;
            myslot_q <= hit_slot;
            myexp_q  <= hit_exp;
            rdata_q  <= '0;
            if (dec_block) begin
              // Block transfers are refused without touching memory.
              status_q <= STATUS_ERROR;
              state    <= S_ACK;
            end else begin
              status_q <= STATUS_COMPLETE;
              state    <= (tm1 == TM1_WRITE) ? S_WDATA : S_MEM;
            end
          end
        end
        S_WDATA: begin
          wdata_q <= a;
          state   <= S_MEM;
        end
        S_MEM: begin
          if (mem_ready) begin
            rdata_q <= mem_rdata & lane_bits(lanes_q);
            state   <= S_ACK;
          end else if (timeout_hit) begin
            status_q <= STATUS_TIMEOUT;
            rdata_q  <= '0;
            state    <= S_ACK;
          end
        end
        default: begin
          // ACK lasts one clock; slot/expansion hit flags end with the cycle.
          myslot_q <= 1'b0;
          myexp_q  <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

  // Memory port and NuBus return drivers, all decoded from current state.
  always_comb begin
    ack         = (state == S_ACK);
    mem_valid   = (state == S_MEM);
    mem_write   = (state == S_MEM && write_q) ? lanes_q : 4'b0000;
    mem_addr    = {addr_q, 2'b00};
    mem_wdata   = wdata_q;
    mem_myslot  = myslot_q;
    mem_myexp   = myexp_q;
    nub_ackn_oe = ack;
    nub_ackn_o  = ~ack;
    nub_tmn_oe  = ack;
    nub_tm1n_o  = ack ? ~status_q[1] : 1'b1;
    nub_tm0n_o  = ack ? ~status_q[0] : 1'b1;
    nub_adn_oe  = ack && !write_q;
    nub_adn_o   = (ack && !write_q) ? ~rdata_q : 32'hFFFF_FFFF;
  end

endmodule
